jtag_dbg_chain_mux: RTL and testbench

Debug-chain multiplexer behind the TAP's DEBUG instruction. It shares the single serial debug link (dbg_sel/dbg_tdi/dbg_tdo) between NMOD debug modules. A module-select header in each DR scan either re-targets the link or routes the remainder of the scan to the currently selected module. It runs entirely in the TCK domain, next to the TAP controller.

---
 rtl/jtag_dbg_chain_mux_if.sv | 33 +++
 rtl/jtag_dbg_chain_mux.sv | 109 ++++++++++
 tb/tb_jtag_dbg_chain_mux.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/jtag_dbg_chain_mux_if.sv
// Debug-chain link between the TAP side and the module multiplexer.
// The mux consumes the TAP decodes and fans the serial link out to NMOD modules.
interface jtag_dbg_chain_mux_if #(
  parameter int NMOD = 4,
  parameter int MODW = 2
);
  logic            tap_TestLogicReset;
  logic            tap_CaptureDR;
  logic            tap_ShiftDR;
  logic            tap_PauseDR;
  logic            tap_UpdateDR;
  logic            dbg_sel;
  logic            dbg_tdi;
  logic            dbg_tdo;
  logic [NMOD-1:0] mod_sel;
  logic            mod_tdi;
  logic [NMOD-1:0] mod_tdo;
  logic            mod_capture_dr;
  logic            mod_shift_dr;
  logic            mod_update_dr;

  modport master (
    output tap_TestLogicReset, tap_CaptureDR, tap_ShiftDR, tap_PauseDR, tap_UpdateDR,
    output dbg_sel, dbg_tdi, mod_tdo,
    input  dbg_tdo, mod_sel, mod_tdi, mod_capture_dr, mod_shift_dr, mod_update_dr
  );

  modport slave (
    input  tap_TestLogicReset, tap_CaptureDR, tap_ShiftDR, tap_PauseDR, tap_UpdateDR,
    input  dbg_sel, dbg_tdi, mod_tdo,
    output dbg_tdo, mod_sel, mod_tdi, mod_capture_dr, mod_shift_dr, mod_update_dr
  );
endinterface

// File: rtl/jtag_dbg_chain_mux.sv
// Shares the DEBUG-instruction serial link between NMOD debug modules. A header bit
// per DR scan either loads a new module ID (1) or routes the rest of the scan (0).
module jtag_dbg_chain_mux #(
  parameter int NMOD = 4,
  parameter int MODW = 2
) (
  input  logic                 jtag_tck,
  input  logic                 jtag_trstn,
  jtag_dbg_chain_mux_if.slave  bus
);
  localparam int              CW       = $clog2(MODW + 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(MODW);
  localparam logic [MODW:0]   ID_LIMIT = (MODW + 1)'(NMOD);

  typedef enum logic [1:0] {IDLE, HDR, SELECT, ROUTE} phase_e;

  phase_e          r_phase,     w_phase_nxt;
  logic [CW-1:0]   r_cnt,       w_cnt_nxt;
  logic [MODW-1:0] r_id_sr,     w_id_sr_nxt;
  logic [MODW-1:0] r_active_id, w_active_id_nxt;
  logic            r_valid,     w_valid_nxt;
  logic [MODW:0]   w_id_shift;
  logic            w_shift;
  logic            w_route;

  // TAP decodes are mutually exclusive; masking with PauseDR makes the hold explicit.
  assign w_shift    = bus.tap_ShiftDR & ~bus.tap_PauseDR;
  assign w_id_shift = {bus.dbg_tdi, r_id_sr};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge jtag_tck or negedge jtag_trstn) begin
    if (!jtag_trstn) begin
      r_phase     <= IDLE;
      r_cnt       <= '0;
      r_id_sr     <= '0;
      r_active_id <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_phase     <= w_phase_nxt;
      r_cnt       <= w_cnt_nxt;
      r_id_sr     <= w_id_sr_nxt;
      r_active_id <= w_active_id_nxt;
      r_valid     <= w_valid_nxt;
    end
  end

  // NOTE: every next-state value is defaulted to "hold" first so no latch can be inferred.
  always_comb begin
    w_phase_nxt     = r_phase;
    w_cnt_nxt       = r_cnt;
    w_id_sr_nxt     = r_id_sr;
    w_active_id_nxt = r_active_id;
    w_valid_nxt     = r_valid;

    if (bus.tap_TestLogicReset) begin
      w_phase_nxt     = IDLE;
      w_cnt_nxt       = '0;
      w_id_sr_nxt     = '0;
      w_active_id_nxt = '0;
      w_valid_nxt     = 1'b0;
    end else if (bus.tap_UpdateDR) begin
      w_phase_nxt = IDLE;
      // Only a complete select scan re-targets; a short one leaves the selection alone.
      if (bus.dbg_sel && (r_phase == SELECT) && (r_cnt == CNT_FULL)) begin
        if ({1'b0, r_id_sr} < ID_LIMIT) begin
          w_active_id_nxt = r_id_sr;
          w_valid_nxt     = 1'b1;
        end else begin
          w_valid_nxt     = 1'b0;
        end
      end
    end else if (bus.tap_CaptureDR) begin
      if (bus.dbg_sel) begin
        w_phase_nxt = HDR;
        w_cnt_nxt   = '0;
      end else begin
        w_phase_nxt = IDLE;
      end
    end else if (w_shift && bus.dbg_sel) begin
      unique case (r_phase)
        HDR:     w_phase_nxt = bus.dbg_tdi ? SELECT : ROUTE;
        SELECT: begin
          if (r_cnt < CNT_FULL) begin
            w_id_sr_nxt = w_id_shift[MODW:1];
            w_cnt_nxt   = r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.mod_sel = '0;
    bus.dbg_tdo = 1'b0;
    for (int i = 0; i < NMOD; i++) begin
      if (r_valid && (r_active_id == MODW'(i))) begin
        bus.mod_sel[i] = 1'b1;
        bus.dbg_tdo    = bus.mod_tdo[i];
      end
    end
  end

  assign w_route            = bus.dbg_sel & r_valid & (r_phase == ROUTE);
  assign bus.mod_tdi        = bus.dbg_tdi;
  assign bus.mod_capture_dr = bus.dbg_sel & r_valid & bus.tap_CaptureDR;
  assign bus.mod_shift_dr   = w_route & w_shift;
  assign bus.mod_update_dr  = w_route & bus.tap_UpdateDR;
endmodule

// File: tb/tb_jtag_dbg_chain_mux.sv
// Drives whole DR scans into two mux instances (NMOD=4 and NMOD=3) and checks them
// against a scan-level model of which module is selected.
module tb_jtag_dbg_chain_mux;
  localparam int MODW = 2;

  logic       tck = 1'b0;
  logic       trstn = 1'b0;
  logic       tlr = 1'b0, cap = 1'b0, shf = 1'b0, pse = 1'b0, upd = 1'b0;
  logic       sel = 1'b0, tdi = 1'b0;
  logic [3:0] mtdo = '0;

  int n_cmp = 0;
  int n_err = 0;
  int sel4 = -1, sel3 = -1;
  int cap4, shf4, upd4, cap3, shf3, upd3;

  always #5 tck = ~tck;

  jtag_dbg_chain_mux_if #(.NMOD(4), .MODW(MODW)) bus4 ();
  jtag_dbg_chain_mux_if #(.NMOD(3), .MODW(MODW)) bus3 ();

  assign bus4.tap_TestLogicReset = tlr;
  assign bus4.tap_CaptureDR      = cap;
  assign bus4.tap_ShiftDR        = shf;
  assign bus4.tap_PauseDR        = pse;
  assign bus4.tap_UpdateDR       = upd;
  assign bus4.dbg_sel            = sel;
  assign bus4.dbg_tdi            = tdi;
  assign bus4.mod_tdo            = mtdo;
  assign bus3.tap_TestLogicReset = tlr;
  assign bus3.tap_CaptureDR      = cap;
  assign bus3.tap_ShiftDR        = shf;
  assign bus3.tap_PauseDR        = pse;
  assign bus3.tap_UpdateDR       = upd;
  assign bus3.dbg_sel            = sel;
  assign bus3.dbg_tdi            = tdi;
  assign bus3.mod_tdo            = mtdo[2:0];

  jtag_dbg_chain_mux #(.NMOD(4), .MODW(MODW)) dut4 (.jtag_tck(tck), .jtag_trstn(trstn), .bus(bus4));
  jtag_dbg_chain_mux #(.NMOD(3), .MODW(MODW)) dut3 (.jtag_tck(tck), .jtag_trstn(trstn), .bus(bus3));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] onehot(input int m);
    return (m < 0) ? 32'd0 : (32'd1 << m);
  endfunction

  function automatic logic exp_tdo(input int m, input logic [3:0] t);
    return (m < 0) ? 1'b0 : t[m];
  endfunction

  // Selection after a completed scan: only a full-length select scan re-targets.
  function automatic int next_sel(input int m, input int nmod, input bit s,
                                  input logic [15:0] bits, input int len);
    int id;
    if (!s || !bits[0] || len < 1 + MODW) return m;
    id = int'(bits[1]) + 2 * int'(bits[2]);
    return (id < nmod) ? id : -1;
  endfunction

  // One TCK cycle: drive after negedge, check outputs before the next posedge.
  task automatic tick(input bit c, input bit s, input bit p, input bit u, input bit t, input bit d);
    @(negedge tck);
    cap = c; shf = s; pse = p; upd = u; tlr = t; tdi = d;
    mtdo = 4'($urandom);
    #1;
    check("mod_sel4", bus4.mod_sel, onehot(sel4));
    check("mod_sel3", bus3.mod_sel, onehot(sel3));
    check("dbg_tdo4", bus4.dbg_tdo, exp_tdo(sel4, mtdo));
    check("dbg_tdo3", bus3.dbg_tdo, exp_tdo(sel3, mtdo));
    check("mod_tdi", bus4.mod_tdi, tdi);
    cap4 += int'(bus4.mod_capture_dr); shf4 += int'(bus4.mod_shift_dr); upd4 += int'(bus4.mod_update_dr);
    cap3 += int'(bus3.mod_capture_dr); shf3 += int'(bus3.mod_shift_dr); upd3 += int'(bus3.mod_update_dr);
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom));
  endtask

  task automatic check_strobes(input string tag, input int m, input int c, input int sh, input int u,
                               input bit s, input bit hdr, input int len);
    bit v;
    v = s && (m >= 0);
    check({"capture_cnt", tag}, c, v ? 1 : 0);
    check({"shift_cnt", tag}, sh, (v && !hdr) ? len - 1 : 0);
    check({"update_cnt", tag}, u, (v && !hdr) ? 1 : 0);
  endtask

  // Full DR scan: Capture, len Shift cycles (optional pause), Exit1, Update, one idle cycle.
  task automatic dr_scan(input bit s, input logic [15:0] bits, input int len, input int pause_at);
    cap4 = 0; shf4 = 0; upd4 = 0; cap3 = 0; shf3 = 0; upd3 = 0;
    sel = s;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom));
    for (int i = 0; i < len; i++) begin
      if (pause_at > 0 && i == pause_at) begin
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom));
        repeat (5) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'($urandom));
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom));
      end
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, bits[i]);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom));
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'($urandom));
    check_strobes("4", sel4, cap4, shf4, upd4, s, bits[0], len);
    check_strobes("3", sel3, cap3, shf3, upd3, s, bits[0], len);
    sel4 = next_sel(sel4, 4, s, bits, len);
    sel3 = next_sel(sel3, 3, s, bits, len);
    idle();
  endtask

  // Select scan interrupted by TestLogicReset after a few header/ID bits.
  task automatic tlr_abort(input int nbits);
    sel = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, (i == 0) ? 1'b1 : 1'($urandom));
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    sel4 = -1; sel3 = -1;
    idle();
  endtask

  // Routed scan interrupted by the asynchronous TAP reset.
  task automatic trst_abort();
    sel = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge tck);
    cap = 1'b0; shf = 1'b0; trstn = 1'b0;
    #1;
    check("trst_mod_sel4", bus4.mod_sel, 32'd0);
    check("trst_shift4", bus4.mod_shift_dr, 32'd0);
    #1 trstn = 1'b1;
    sel4 = -1; sel3 = -1;
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] bits;
    int len, pause_at;
    bit s;

    // Reset: everything quiet even with capture asserted and all module TDOs high.
    sel = 1'b1; cap = 1'b1; mtdo = 4'hF;
    #2;
    check("rst_mod_sel", bus4.mod_sel, 32'd0);
    check("rst_dbg_tdo", bus4.dbg_tdo, 32'd0);
    check("rst_capture", bus4.mod_capture_dr, 32'd0);
    #20 trstn = 1'b1;
    cap = 1'b0;
    repeat (2) idle();

    dr_scan(1'b1, 16'b101, 3, 0);                  // select ID 2
    check("sel2_mod_sel", bus4.mod_sel, 32'b0100);
    @(negedge tck); mtdo = 4'b0100; #1;
    check("sel2_tdo_hi", bus4.dbg_tdo, 32'd1);
    mtdo = 4'b1011; #1;
    check("sel2_tdo_lo", bus4.dbg_tdo, 32'd0);

    dr_scan(1'b1, 16'h01AA, 9, 0);                 // routed 9-bit scan
    dr_scan(1'b1, 16'b11, 2, 0);                   // short select scan
    dr_scan(1'b1, 16'b111, 3, 0);                  // ID 3: valid in NMOD=4, invalid in NMOD=3
    dr_scan(1'b1, 16'h0034, 7, 0);                 // routed; NMOD=3 instance must stay silent
    dr_scan(1'b1, 16'b011, 3, 2);                  // paused select scan, ID 1
    check("pause_mod_sel", bus4.mod_sel, 32'b0010);
    dr_scan(1'b0, 16'h00F0, 8, 0);                 // dbg_sel low: no strobes, selection kept
    tlr_abort(2);
    dr_scan(1'b1, 16'b001, 3, 0);                  // reselect ID 0 ...
    trst_abort();                                  // ... then async reset mid-scan
    dr_scan(1'b1, 16'h0006, 5, 0);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(19) == 0) begin
        tlr_abort($urandom_range(3));
      end else begin
        s    = ($urandom_range(4) != 0);
        bits = 16'($urandom);
        bits[0] = 1'($urandom);
        len  = bits[0] ? 1 + $urandom_range(3) : 1 + $urandom_range(11);
        pause_at = (len > 1 && $urandom_range(3) == 0) ? 1 + $urandom_range(len - 2) : 0;
        dr_scan(s, bits, len, pause_at);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
